// File: rtl/fifo_pkg.sv
// Shared types for the async_fifo read-side packer: FSM state encoding and counter width helper.
package fifo_pkg;

    typedef enum logic [1:0] {FILL, DRAIN, EMIT} pack_state_t;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output beat register for fifo_rd_packer: holds a beat until accepted and
// allows reload in the same cycle the current beat is taken.
module pack_out_reg #(
    parameter int DW   = 8,
    parameter int PACK = 4
) (
    input  logic               rclk,
    input  logic               rrstn,
    input  logic               load,
    input  logic [DW*PACK-1:0] load_data,
    input  logic [PACK-1:0]    load_keep,
    input  logic               m_ready,
    output logic               m_valid,
    output logic [DW*PACK-1:0] m_data,
    output logic [PACK-1:0]    m_keep,
    output logic               free
);

    assign free = !m_valid || m_ready;

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains async_fifo words and packs PACK of them per valid/ready output beat with a keep mask.
// Define PACK_TIMEOUT_EN to auto-flush a partial beat after TIMEOUT idle cycles.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DW      = 8,
    parameter int PACK    = 4,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic               rclk,
    input  logic               rrstn,
    output logic               rden,
    input  logic [DW-1:0]      rd_data,
    input  logic               empty,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW*PACK-1:0] m_data,
    output logic [PACK-1:0]    m_keep
);

    localparam int CW = cnt_w(PACK);
    localparam int LW = $clog2(PACK);

    pack_state_t               state, state_nxt;
    logic [CW-1:0]             fill, inflight, fill_land;
    logic [CW:0]               pend;
    logic [PACK-1:0][DW-1:0]   acc;
    logic                      run, land, flush_evt, emit, out_free;
    logic [DW*PACK-1:0]        beat_data;
    logic [PACK-1:0]           beat_keep;

    // run holds rden low while reset is asserted, even with a non-empty FIFO.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign pend = {1'b0, fill} + {1'b0, inflight};
    assign rden = run && !empty && (state == FILL) && (pend < (CW+1)'(PACK));

    generate
        if (RD_LAT == 0) begin : g_showahead
            assign land     = rden;
            assign inflight = '0;
        end else begin : g_registered
            always_ff @(posedge rclk or negedge rrstn) begin
                if (!rrstn) inflight <= '0;
                else        inflight <= CW'(rden);
            end
            assign land = (inflight != '0);
        end
    endgenerate

`ifdef PACK_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT);
    logic [TW-1:0] idle_cnt;

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn)
            idle_cnt <= '0;
        else if (rden || emit)
            idle_cnt <= '0;
        else if (state == FILL && fill != '0 && idle_cnt != TW'(TIMEOUT))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign flush_evt = flush || (idle_cnt == TW'(TIMEOUT));
`else
    assign flush_evt = flush;
`endif

    assign fill_land = fill + CW'(land);

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            // A full accumulator wins over a same-cycle flush.
            FILL: begin
                if (fill_land == CW'(PACK))
                    state_nxt = EMIT;
                else if (flush_evt && pend != '0)
                    state_nxt = DRAIN;
            end
            // inflight is at most one word, and it lands in this cycle.
            DRAIN: state_nxt = EMIT;
            EMIT: begin
                if (out_free) begin
                    emit      = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state <= FILL;
            fill  <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (emit) begin
                fill <= '0;
                acc  <= '0;
            end else if (land) begin
                fill              <= fill_land;
                acc[fill[LW-1:0]] <= rd_data;
            end
        end
    end

    always_comb begin
        beat_keep = '0;
        beat_data = '0;
        for (int i = 0; i < PACK; i++) begin
            beat_keep[i] = (i < int'(fill));
            if (beat_keep[i]) beat_data[i*DW +: DW] = acc[i];
        end
    end

    pack_out_reg #(.DW(DW), .PACK(PACK)) u_out (
        .rclk      (rclk),
        .rrstn     (rrstn),
        .load      (emit),
        .load_data (beat_data),
        .load_keep (beat_keep),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .free      (out_free)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DW=8, PACK=4, RD_LAT=1) with a registered-read FIFO model.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrstn;
    logic        rden;
    logic [7:0]  rd_data = 8'h00;
    logic        empty;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int empty_rd_err = 0;

    logic [7:0]  fifo_q[$];
    logic [31:0] beat_d[$];
    logic [3:0]  beat_k[$];

    fifo_rd_packer #(.DW(8), .PACK(4), .RD_LAT(1), .TIMEOUT(16)) dut (
        .rclk    (rclk),
        .rrstn   (rrstn),
        .rden    (rden),
        .rd_data (rd_data),
        .empty   (empty),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep)
    );

    always #5 rclk = ~rclk;

    // FIFO model: registered read data, one cycle after the pop.
    always @(posedge rclk) begin
        if (rden) begin
            if (fifo_q.size() == 0) empty_rd_err++;
            else begin
                rd_data <= fifo_q.pop_front();
                pops++;
            end
        end
    end

    always @(negedge rclk) empty = (fifo_q.size() == 0);

    always @(posedge rclk) begin
        if (rrstn && m_valid && m_ready) begin
            beat_d.push_back(m_data);
            beat_k.push_back(m_keep);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic clear_beats();
        beat_d.delete();
        beat_k.delete();
    endtask

    function automatic logic [31:0] beat_at(input int i);
        return (beat_d.size() > i) ? beat_d[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [3:0] keep_at(input int i);
        return (beat_k.size() > i) ? beat_k[i] : 4'hE;
    endfunction

    task automatic test_reset();
        rrstn = 1'b0;
        push(8'hAA); push(8'hB4); push(8'hBE); push(8'hC8);
        repeat (3) @(negedge rclk);
        total++; if (rden !== 1'b0) begin bad++; $display("FAIL reset_rden got=%b exp=0", rden); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", m_valid); end
        total++; if (m_keep !== 4'h0) begin bad++; $display("FAIL reset_mkeep got=%h exp=0", m_keep); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_mdata got=%h exp=0", m_data); end
        pops = 0;
        rrstn = 1'b1;
        @(negedge rclk);
        total++; if (rden !== 1'b1) begin bad++; $display("FAIL reset_first_rden got=%b exp=1", rden); end
    endtask

    task automatic test_full_beat();
        clear_beats();
        m_ready = 1'b1;
        repeat (20) @(negedge rclk);
        total++; if (beat_d.size() != 1) begin bad++; $display("FAIL full_count got=%0d exp=1", beat_d.size()); end
        total++; if (beat_at(0) !== 32'hC8BEB4AA) begin bad++; $display("FAIL full_data got=%h exp=c8beb4aa", beat_at(0)); end
        total++; if (keep_at(0) !== 4'hF) begin bad++; $display("FAIL full_keep got=%h exp=f", keep_at(0)); end
        total++; if (pops != 4) begin bad++; $display("FAIL full_pops got=%0d exp=4", pops); end
    endtask

    task automatic test_backpressure();
        logic seen;
        int   unstable;
        seen = 1'b0;
        unstable = 0;
        clear_beats();
        pops = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (20) begin
            @(negedge rclk);
            if (m_valid) seen = 1'b1;
            if (seen && (!m_valid || m_data !== 32'h04030201 || m_keep !== 4'hF)) unstable++;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_beat0_seen got=%b exp=1", seen); end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        total++; if (pops != 8) begin bad++; $display("FAIL bp_pops got=%0d exp=8", pops); end
        total++; if (rden !== 1'b0) begin bad++; $display("FAIL bp_rden_stalled got=%b exp=0", rden); end
        m_ready = 1'b1;
        @(negedge rclk);
        total++; if (m_valid !== 1'b1 || m_data !== 32'h08070605) begin
            bad++; $display("FAIL bp_beat1_next got=%b/%h exp=1/08070605", m_valid, m_data);
        end
        repeat (3) @(negedge rclk);
        total++; if (beat_d.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", beat_d.size()); end
        total++; if (beat_at(0) !== 32'h04030201) begin bad++; $display("FAIL bp_beat0 got=%h exp=04030201", beat_at(0)); end
        total++; if (beat_at(1) !== 32'h08070605) begin bad++; $display("FAIL bp_beat1 got=%h exp=08070605", beat_at(1)); end
    endtask

    task automatic test_flush();
        clear_beats();
        push(8'h11); push(8'h22);
        repeat (8) @(negedge rclk);
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        repeat (6) @(negedge rclk);
        total++; if (beat_d.size() != 1) begin bad++; $display("FAIL flush_count got=%0d exp=1", beat_d.size()); end
        total++; if (beat_at(0) !== 32'h00002211) begin bad++; $display("FAIL flush_data got=%h exp=00002211", beat_at(0)); end
        total++; if (keep_at(0) !== 4'b0011) begin bad++; $display("FAIL flush_keep got=%b exp=0011", keep_at(0)); end
        total++; if (dut.fill !== 3'd0) begin bad++; $display("FAIL flush_fill got=%0d exp=0", dut.fill); end
        total++; if (dut.state !== fifo_pkg::FILL) begin bad++; $display("FAIL flush_state got=%0d exp=FILL", dut.state); end
    endtask

    task automatic test_flush_inflight();
        clear_beats();
        pops = 0;
        push(8'h33); push(8'h44); push(8'h55);
        for (int i = 0; i < 20 && pops < 3; i++) @(negedge rclk);
        total++; if (pops != 3) begin bad++; $display("FAIL inflight_pops got=%0d exp=3", pops); end
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        repeat (6) @(negedge rclk);
        total++; if (beat_d.size() != 1) begin bad++; $display("FAIL inflight_count got=%0d exp=1", beat_d.size()); end
        total++; if (beat_at(0) !== 32'h00554433) begin bad++; $display("FAIL inflight_data got=%h exp=00554433", beat_at(0)); end
        total++; if (keep_at(0) !== 4'b0111) begin bad++; $display("FAIL inflight_keep got=%b exp=0111", keep_at(0)); end
        clear_beats();
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        repeat (10) @(negedge rclk);
        total++; if (beat_d.size() != 0) begin bad++; $display("FAIL empty_flush_count got=%0d exp=0", beat_d.size()); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL empty_flush_mvalid got=%b exp=0", m_valid); end
    endtask

    task automatic test_timeout();
        clear_beats();
        push(8'h5A); push(8'h6B); push(8'h7C);
`ifdef PACK_TIMEOUT_EN
        repeat (40) @(negedge rclk);
        total++; if (beat_d.size() != 1) begin bad++; $display("FAIL timeout_count got=%0d exp=1", beat_d.size()); end
        total++; if (beat_at(0) !== 32'h007C6B5A) begin bad++; $display("FAIL timeout_data got=%h exp=007c6b5a", beat_at(0)); end
        total++; if (keep_at(0) !== 4'b0111) begin bad++; $display("FAIL timeout_keep got=%b exp=0111", keep_at(0)); end
`else
        repeat (100) @(negedge rclk);
        total++; if (beat_d.size() != 0) begin bad++; $display("FAIL no_timeout_count got=%0d exp=0", beat_d.size()); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL no_timeout_mvalid got=%b exp=0", m_valid); end
        total++; if (dut.fill !== 3'd3) begin bad++; $display("FAIL no_timeout_fill got=%0d exp=3", dut.fill); end
`endif
    endtask

    task automatic test_reset_mid_fill();
        clear_beats();
`ifdef PACK_TIMEOUT_EN
        push(8'h01); push(8'h02);
        repeat (6) @(negedge rclk);
`endif
        rrstn = 1'b0;
        repeat (2) @(negedge rclk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_mvalid got=%b exp=0", m_valid); end
        total++; if (rden !== 1'b0) begin bad++; $display("FAIL midrst_rden got=%b exp=0", rden); end
        rrstn = 1'b1;
        repeat (20) @(negedge rclk);
        total++; if (dut.fill !== 3'd0) begin bad++; $display("FAIL midrst_fill got=%0d exp=0", dut.fill); end
        total++; if (beat_d.size() != 0) begin bad++; $display("FAIL midrst_nobeat got=%0d exp=0", beat_d.size()); end
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        repeat (20) @(negedge rclk);
        total++; if (beat_at(0) !== 32'hE4E3E2E1) begin bad++; $display("FAIL midrst_after_data got=%h exp=e4e3e2e1", beat_at(0)); end
        total++; if (keep_at(0) !== 4'hF) begin bad++; $display("FAIL midrst_after_keep got=%h exp=f", keep_at(0)); end
    endtask

    initial begin
        rrstn   = 1'b0;
        empty   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_full_beat();
        test_backpressure();
        test_flush();
        test_flush_inflight();
        test_timeout();
        test_reset_mid_fill();
        total++; if (empty_rd_err != 0) begin bad++; $display("FAIL rden_on_empty got=%0d exp=0", empty_rd_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
